commit_log_collector: RTL

// Producer side of the commit-log interface. Gathers up to NUM_WB commit records per cycle

---
 rtl/drac_pkg.sv | 14 +
 rtl/commit_log_collector_if.sv | 28 ++
 rtl/commit_log_mwfifo.sv | 68 ++++++
 rtl/commit_log_collector.sv | 86 ++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared core types for the commit-log path: the opaque commit record and the
// default number of writeback lanes feeding the commit logger.
package drac_pkg;

    localparam int unsigned COMMIT_LOG_LANES = 2;

    typedef struct packed {
        logic [39:0] pc;
        logic [31:0] inst;
        logic [5:0]  rd_addr;
        logic        rd_we;
    } commit_data_t;

endpackage : drac_pkg

// File: rtl/commit_log_collector_if.sv
// Writeback-to-commit-logger bundle. The collector takes the master view; the
// environment (writeback lanes plus commit logger) takes the slave view.
interface commit_log_collector_if #(
    parameter int unsigned NUM_WB     = drac_pkg::COMMIT_LOG_LANES,
    parameter int unsigned DROP_CNT_W = 16
) ();
    import drac_pkg::*;

    logic                           flush_i;
    logic         [NUM_WB-1:0]      wb_valid_i;
    commit_data_t [NUM_WB-1:0]      wb_data_i;
    logic                           commit_ready_i;
    logic                           commit_valid_o;
    commit_data_t                   commit_data_o;
    logic                           stall_o;
    logic                           overflow_o;
    logic         [DROP_CNT_W-1:0]  drop_cnt_o;

    modport master (
        input  flush_i, wb_valid_i, wb_data_i, commit_ready_i,
        output commit_valid_o, commit_data_o, stall_o, overflow_o, drop_cnt_o
    );

    modport slave (
        output flush_i, wb_valid_i, wb_data_i, commit_ready_i,
        input  commit_valid_o, commit_data_o, stall_o, overflow_o, drop_cnt_o
    );
endinterface : commit_log_collector_if

// File: rtl/commit_log_mwfifo.sv
// Multi-write, single-read FIFO: up to NUM_WB already-compacted records per cycle
// land at consecutive slots from wr_ptr; the head is presented show-ahead.
module commit_log_mwfifo
    import drac_pkg::*;
#(
    parameter int unsigned NUM_WB = COMMIT_LOG_LANES,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic        [CNT_W-1:0]  wr_cnt_i,
    input  commit_data_t [NUM_WB-1:0] wr_data_i,
    input  logic                     pop_i,
    output logic        [CNT_W-1:0]  count_o,
    output commit_data_t             rd_data_o
);
    commit_data_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt_i);
            count_d  = count_q + wr_cnt_i - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count gates validity, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (CNT_W'(k) < wr_cnt_i) begin
                    mem_q[wr_ptr_q + PTR_W'(k)] <= wr_data_i[k];
                end
            end
        end
    end

    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

endmodule : commit_log_mwfifo

// File: rtl/commit_log_collector.sv
// Producer side of the commit-log interface: compacts valid writeback lanes into
// the FIFO in program order, back-pressures writeback and counts dropped records.
module commit_log_collector
    import drac_pkg::*;
#(
    parameter int unsigned NUM_WB     = COMMIT_LOG_LANES,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    commit_log_collector_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic         [CNT_W-1:0]      count;
    logic         [CNT_W-1:0]      space;
    logic         [CNT_W-1:0]      n_valid, n_write, n_drop;
    logic                          pop;
    commit_data_t [NUM_WB-1:0]     wr_data;
    commit_data_t                  head_data;
    logic                          overflow_q, overflow_d;
    logic         [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic         [DROP_CNT_W:0]   drop_sum;

    assign pop   = (count != '0) && bus.commit_ready_i && !bus.flush_i;
    assign space = CNT_W'(DEPTH) - count + CNT_W'(pop);

    // Valid lanes pack into write ports 0.. in ascending lane order, skipping gaps.
    always_comb begin
        int slot;
        slot    = 0;
        wr_data = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (bus.wb_valid_i[i]) begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (k == slot) wr_data[k] = bus.wb_data_i[i];
                end
                slot++;
            end
        end
        n_valid = CNT_W'(slot);
        n_write = '0;
        n_drop  = '0;
        if (!bus.flush_i) begin
            n_write = (n_valid <= space) ? n_valid : space;
            n_drop  = n_valid - n_write;
        end
    end

    assign drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(n_drop);
    assign drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    assign overflow_d = overflow_q || (n_drop != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    commit_log_mwfifo #(
        .NUM_WB (NUM_WB),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (bus.flush_i),
        .wr_cnt_i  (n_write),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .count_o   (count),
        .rd_data_o (head_data)
    );

    // Stall looks only at registered occupancy so writeback sees no combinational loop.
    assign bus.stall_o        = (CNT_W'(DEPTH) - count) < CNT_W'(NUM_WB);
    assign bus.commit_valid_o = (count != '0);
    assign bus.commit_data_o  = head_data;
    assign bus.overflow_o     = overflow_q;
    assign bus.drop_cnt_o     = drop_cnt_q;

endmodule : commit_log_collector
